// File: rtl/ssd1306_command_controller_if.sv
// SSD1306 controller bus: SPI-side byte/strobe inputs and RAM/display-state outputs.
// Latency: none (wiring only).
// Backpressure: none; the byte source is never stalled.
interface ssd1306_command_controller_if #(
    parameter int ADDRESS_WIDTH = 11
);
    logic                     ByteValid_i;
    logic [7:0]               Byte_i;
    logic                     DC_i;
    logic                     TransmissionStart_i;
    logic                     WriteEnable_o;
    logic [ADDRESS_WIDTH-1:0] WriteAddress_o;
    logic [7:0]               WriteData_o;
    logic                     DisplayOn_o;
    logic                     Invert_o;
    logic [7:0]               Contrast_o;

    // Byte source side: drives the SPI byte stream, observes writes and display state.
    modport master (
        output ByteValid_i, Byte_i, DC_i, TransmissionStart_i,
        input  WriteEnable_o, WriteAddress_o, WriteData_o, DisplayOn_o, Invert_o, Contrast_o
    );

    // Controller side.
    modport slave (
        input  ByteValid_i, Byte_i, DC_i, TransmissionStart_i,
        output WriteEnable_o, WriteAddress_o, WriteData_o, DisplayOn_o, Invert_o, Contrast_o
    );
endinterface

// File: rtl/ssd1306_command_controller.sv
// Parses SSD1306 command/data bytes into display registers and bitmap-RAM writes.
// Latency: one clock from ByteValid_i (data) to the WriteEnable_o strobe.
// Backpressure: none; every byte is accepted, back-to-back pulses each produce a strobe.
// Optional: define SSD1306_CS_RESYNC_EN to restart parser and address pointers on TransmissionStart_i.
module ssd1306_command_controller #(
    parameter int COLUMNS       = 128,
    parameter int PAGES         = 8,
    parameter int ADDRESS_WIDTH = 11
) (
    input logic                          Clock,
    input logic                          Reset,
    ssd1306_command_controller_if.slave  bus
);
    localparam int CW = $clog2(COLUMNS);
    localparam int PW = 3;
    localparam logic [CW-1:0] COL_MAX  = CW'(COLUMNS - 1);
    localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);

    localparam logic [1:0] ST_CMD  = 2'd0;
    localparam logic [1:0] ST_ARG1 = 2'd1;
    localparam logic [1:0] ST_ARG2 = 2'd2;

    localparam logic [1:0] MODE_HORZ = 2'b00;
    localparam logic [1:0] MODE_VERT = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;

    logic [1:0]    state, state_r, state_n;
    logic [7:0]    op, op_n;
    logic [1:0]    mode, mode_n;
    logic [CW-1:0] col, col_r, col_n, col_start, col_start_n, col_end, col_end_n;
    logic [PW-1:0] page, page_r, page_n, page_start, page_start_n, page_end, page_end_n;
    logic          cw, pw;

    logic                     we, we_n;
    logic [ADDRESS_WIDTH-1:0] addr, addr_n;
    logic [7:0]               wdata, wdata_n;
    logic                     disp_on, disp_on_n;
    logic                     invert, invert_n;
    logic [7:0]               contrast, contrast_n;

    function automatic logic [PW-1:0] clamp_page(input logic [2:0] v);
        return (v > PAGE_MAX) ? PAGE_MAX : v;
    endfunction

    // Frame resync view of parser/pointers, applied before the byte is interpreted.
    always_comb begin
        state_r = state;
        col_r   = col;
        page_r  = page;
`ifdef SSD1306_CS_RESYNC_EN
        if (bus.TransmissionStart_i) begin
            state_r = ST_CMD;
            col_r   = col_start;
            page_r  = page_start;
        end
`endif
    end

`ifndef SSD1306_CS_RESYNC_EN
    // Frame start has no meaning when pointers persist across CS frames.
    logic unused_ts;
    assign unused_ts = bus.TransmissionStart_i;
`endif

    assign cw = (col_r == col_end) || (col_r == COL_MAX);
    assign pw = (page_r == page_end) || (page_r == PAGE_MAX);

    // Next-state: command parsing, data capture and pointer advance.
    always_comb begin
        state_n      = state_r;
        op_n         = op;
        mode_n       = mode;
        col_n        = col_r;
        page_n       = page_r;
        col_start_n  = col_start;
        col_end_n    = col_end;
        page_start_n = page_start;
        page_end_n   = page_end;
        we_n         = 1'b0;
        addr_n       = addr;
        wdata_n      = wdata;
        disp_on_n    = disp_on;
        invert_n     = invert;
        contrast_n   = contrast;

        if (bus.ByteValid_i && bus.DC_i) begin
            // Data byte: any half-parsed command is abandoned.
            state_n = ST_CMD;
            we_n    = 1'b1;
            wdata_n = bus.Byte_i;
            addr_n  = ADDRESS_WIDTH'({page_r, col_r});
            case (mode)
                MODE_HORZ: begin
                    if (cw) begin
                        col_n  = col_start;
                        page_n = pw ? page_start : page_r + PW'(1);
                    end else begin
                        col_n = col_r + CW'(1);
                    end
                end
                MODE_VERT: begin
                    if (pw) begin
                        page_n = page_start;
                        col_n  = cw ? col_start : col_r + CW'(1);
                    end else begin
                        page_n = page_r + PW'(1);
                    end
                end
                default: col_n = (col_r == COL_MAX) ? '0 : col_r + CW'(1);
            endcase
        end else if (bus.ByteValid_i) begin
            case (state_r)
                ST_CMD: begin
                    case (bus.Byte_i)
                        8'h20, 8'h21, 8'h22, 8'h81,
                        8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
                            op_n    = bus.Byte_i;
                            state_n = ST_ARG1;
                        end
                        default: begin
                            if (bus.Byte_i[7:4] == 4'h0)
                                col_n[3:0] = bus.Byte_i[3:0];
                            else if (bus.Byte_i[7:4] == 4'h1)
                                col_n[CW-1:4] = bus.Byte_i[CW-5:0];
                            else if (bus.Byte_i[7:3] == 5'b10110)
                                page_n = clamp_page(bus.Byte_i[2:0]);
                            else if (bus.Byte_i[7:1] == 7'b1010011)
                                invert_n = bus.Byte_i[0];
                            else if (bus.Byte_i[7:1] == 7'b1010111)
                                disp_on_n = bus.Byte_i[0];
                        end
                    endcase
                end
                ST_ARG1: begin
                    state_n = ST_CMD;
                    case (op)
                        8'h20: if (bus.Byte_i[1:0] != 2'b11) mode_n = bus.Byte_i[1:0];
                        8'h21: begin
                            col_start_n = bus.Byte_i[CW-1:0];
                            col_n       = bus.Byte_i[CW-1:0];
                            state_n     = ST_ARG2;
                        end
                        8'h22: begin
                            page_start_n = clamp_page(bus.Byte_i[2:0]);
                            page_n       = clamp_page(bus.Byte_i[2:0]);
                            state_n      = ST_ARG2;
                        end
                        8'h81: contrast_n = bus.Byte_i;
                        default: ;
                    endcase
                end
                ST_ARG2: begin
                    state_n = ST_CMD;
                    if (op == 8'h21)      col_end_n  = bus.Byte_i[CW-1:0];
                    else if (op == 8'h22) page_end_n = clamp_page(bus.Byte_i[2:0]);
                end
                default: state_n = ST_CMD;
            endcase
        end
    end

    // State registers; reset leaves page mode and full-screen window.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_CMD;
            op         <= 8'h00;
            mode       <= MODE_PAGE;
            col        <= '0;
            page       <= '0;
            col_start  <= '0;
            col_end    <= COL_MAX;
            page_start <= '0;
            page_end   <= PAGE_MAX;
            we         <= 1'b0;
            addr       <= '0;
            wdata      <= 8'h00;
            disp_on    <= 1'b0;
            invert     <= 1'b0;
            contrast   <= 8'h7F;
        end else begin
            state      <= state_n;
            op         <= op_n;
            mode       <= mode_n;
            col        <= col_n;
            page       <= page_n;
            col_start  <= col_start_n;
            col_end    <= col_end_n;
            page_start <= page_start_n;
            page_end   <= page_end_n;
            we         <= we_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            disp_on    <= disp_on_n;
            invert     <= invert_n;
            contrast   <= contrast_n;
        end
    end

    assign bus.WriteEnable_o  = we;
    assign bus.WriteAddress_o = addr;
    assign bus.WriteData_o    = wdata;
    assign bus.DisplayOn_o    = disp_on;
    assign bus.Invert_o       = invert;
    assign bus.Contrast_o     = contrast;
endmodule

// File: tb/tb_ssd1306_command_controller.sv
// Directed bench for ssd1306_command_controller: commands, addressing modes, aborts, resets.
// Latency: checks write strobe one clock after each data byte.
// Backpressure: none; bytes are driven on fixed negedges.
module tb_ssd1306_command_controller;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_addr [0:7];

    ssd1306_command_controller_if #(.ADDRESS_WIDTH(11)) bus ();

    ssd1306_command_controller #(.COLUMNS(128), .PAGES(8), .ADDRESS_WIDTH(11)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge Clock);
        bus.ByteValid_i = 1'b1; bus.DC_i = 1'b0; bus.Byte_i = b;
        @(negedge Clock);
        bus.ByteValid_i = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic ts, input int addr);
        @(negedge Clock);
        bus.ByteValid_i = 1'b1; bus.DC_i = 1'b1; bus.Byte_i = b;
        bus.TransmissionStart_i = ts;
        @(negedge Clock);
        bus.ByteValid_i = 1'b0; bus.TransmissionStart_i = 1'b0;
        check("data_we", 32'(bus.WriteEnable_o), 32'd1);
        check("data_addr", 32'(bus.WriteAddress_o), 32'(addr));
        check("data_byte", 32'(bus.WriteData_o), 32'(b));
    endtask

    // Back-to-back data bytes 0xA0+i, expected addresses from exp_addr.
    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (i > 0) begin
                check("burst_we", 32'(bus.WriteEnable_o), 32'd1);
                check("burst_addr", 32'(bus.WriteAddress_o), 32'(exp_addr[i-1]));
                check("burst_byte", 32'(bus.WriteData_o), 32'hA0 + 32'(i - 1));
            end
            bus.ByteValid_i = 1'b1; bus.DC_i = 1'b1; bus.Byte_i = 8'hA0 + 8'(i);
        end
        @(negedge Clock);
        bus.ByteValid_i = 1'b0;
        check("burst_we", 32'(bus.WriteEnable_o), 32'd1);
        check("burst_addr", 32'(bus.WriteAddress_o), 32'(exp_addr[n-1]));
        check("burst_byte", 32'(bus.WriteData_o), 32'hA0 + 32'(n - 1));
        @(negedge Clock);
        check("burst_we_drop", 32'(bus.WriteEnable_o), 32'd0);
        check("burst_addr_hold", 32'(bus.WriteAddress_o), 32'(exp_addr[n-1]));
    endtask

    initial begin
        bus.ByteValid_i = 1'b0; bus.Byte_i = 8'h00; bus.DC_i = 1'b0;
        bus.TransmissionStart_i = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_we", 32'(bus.WriteEnable_o), 32'd0);
        check("rst_addr", 32'(bus.WriteAddress_o), 32'd0);
        check("rst_data", 32'(bus.WriteData_o), 32'd0);
        check("rst_contrast", 32'(bus.Contrast_o), 32'h7F);
        check("rst_disp", 32'(bus.DisplayOn_o), 32'd0);
        check("rst_inv", 32'(bus.Invert_o), 32'd0);
        Reset = 1'b0;

        // First data byte lands at address 0, then column advances.
        send_data(8'h55, 1'b0, 0);
        @(negedge Clock);
        check("we_single_cycle", 32'(bus.WriteEnable_o), 32'd0);
        check("data_hold", 32'(bus.WriteData_o), 32'h55);
        send_data(8'h56, 1'b0, 1);

        // Horizontal mode, cols 126..127, pages 2..3.
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h02); send_cmd(8'h03);
        exp_addr[0] = 382; exp_addr[1] = 383; exp_addr[2] = 510;
        exp_addr[3] = 511; exp_addr[4] = 382;
        burst(5);

        // Vertical mode, cols 16..17, pages 6..7.
        send_cmd(8'h20); send_cmd(8'h01);
        send_cmd(8'h21); send_cmd(8'h10); send_cmd(8'h11);
        send_cmd(8'h22); send_cmd(8'h06); send_cmd(8'h07);
        exp_addr[0] = 784; exp_addr[1] = 912; exp_addr[2] = 785;
        exp_addr[3] = 913; exp_addr[4] = 784;
        burst(5);

        // Page mode with explicit pointer commands; column wraps, page kept.
        send_cmd(8'h20); send_cmd(8'h02);
        send_cmd(8'hB3); send_cmd(8'h0F); send_cmd(8'h17);
        exp_addr[0] = 511; exp_addr[1] = 384;
        burst(2);

        // Display state registers.
        send_cmd(8'h81); send_cmd(8'hCC); send_cmd(8'hAF); send_cmd(8'hA7);
        @(negedge Clock);
        check("contrast", 32'(bus.Contrast_o), 32'hCC);
        check("disp_on", 32'(bus.DisplayOn_o), 32'd1);
        check("invert_on", 32'(bus.Invert_o), 32'd1);

        // Data aborts a pending 0x81 and is still written (page 3, col 1).
        send_cmd(8'h81);
        send_data(8'h12, 1'b0, 385);
        check("abort_contrast", 32'(bus.Contrast_o), 32'hCC);
        send_cmd(8'hAE); send_cmd(8'hA6);
        @(negedge Clock);
        check("disp_off", 32'(bus.DisplayOn_o), 32'd0);
        check("invert_off", 32'(bus.Invert_o), 32'd0);

        // Frame start in the middle of a contrast command.
        send_cmd(8'h81);
        @(negedge Clock);
        bus.TransmissionStart_i = 1'b1;
        @(negedge Clock);
        bus.TransmissionStart_i = 1'b0;
        send_cmd(8'h40);
        @(negedge Clock);
`ifdef SSD1306_CS_RESYNC_EN
        check("ts_mid_cmd", 32'(bus.Contrast_o), 32'hCC);
`else
        check("ts_mid_cmd", 32'(bus.Contrast_o), 32'h40);
`endif

        // Horizontal window starting col 4 / page 1, then frame start with data.
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h04); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h01); send_cmd(8'h07);
        exp_addr[0] = 132; exp_addr[1] = 133; exp_addr[2] = 134;
        burst(3);
`ifdef SSD1306_CS_RESYNC_EN
        send_data(8'h77, 1'b1, 132);
`else
        send_data(8'h77, 1'b1, 135);
`endif

        // Reset in the middle of a command drops the pending argument.
        send_cmd(8'h81);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_we", 32'(bus.WriteEnable_o), 32'd0);
        check("midrst_addr", 32'(bus.WriteAddress_o), 32'd0);
        Reset = 1'b0;
        send_cmd(8'hAF);
        @(negedge Clock);
        check("midrst_contrast", 32'(bus.Contrast_o), 32'h7F);
        check("midrst_disp", 32'(bus.DisplayOn_o), 32'd1);
        send_data(8'h3C, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
